// File: rtl/op_encoder.sv
// op_encoder: conditions four raw buttons into one-hot op codes, each held stable
// across exactly one rising edge of the slow game clock clk_6.
module op_encoder #(
  parameter int DEBOUNCE      = 8,
  parameter int REPEAT_DELAY  = 300,
  parameter int REPEAT_PERIOD = 170,
  parameter int LOAD_WINDOW   = 40
) (
  input  logic       clk_1000,
  input  logic       restart,
  input  logic [3:0] btn_raw,
  input  logic       clk_6,
  output logic [3:0] op,
  output logic       pending
);
  localparam int DW   = $clog2(DEBOUNCE + 1);
  localparam int HMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int PW   = $clog2(LOAD_WINDOW + 1);
  typedef enum logic [1:0] {IDLE, WAIT, SHOW, CLEAR} state_t;
  state_t state, state_n;
  logic [3:0] b_s1, b_s2, stable, stable_q, press, rep, ev, sel, q, q_n, rpt;
  logic c6_s1, c6_s2, c6_q, c6_fall, c6_rise, win;
  logic [PW-1:0] phase;
  logic [DW-1:0] db_cnt [4];
  logic [HW-1:0] hold [4];
  always_ff @(posedge clk_1000) begin
    if (restart) begin
      b_s1     <= '0;
      b_s2     <= '0;
      stable_q <= '0;
      c6_s1    <= 1'b0;
      c6_s2    <= 1'b0;
      c6_q     <= 1'b0;
    end else begin
      b_s1     <= btn_raw;
      b_s2     <= b_s1;
      stable_q <= stable;
      c6_s1    <= clk_6;
      c6_s2    <= c6_s1;
      c6_q     <= c6_s2;
    end
  end
  always_ff @(posedge clk_1000) begin
    for (int i = 0; i < 4; i++) begin
      if (restart) begin
        db_cnt[i] <= '0;
        stable[i] <= 1'b0;
      end else if (b_s2[i] == stable[i]) begin
        db_cnt[i] <= '0;
      end else if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
        db_cnt[i] <= '0;
        stable[i] <= ~stable[i];
      end else begin
        db_cnt[i] <= db_cnt[i] + 1'b1;
      end
      if (restart || !stable[i]) begin
        hold[i] <= '0;
        rpt[i]  <= 1'b0;
      end else if (rep[i]) begin
        hold[i] <= HW'(1);
        rpt[i]  <= 1'b1;
      end else begin
        hold[i] <= hold[i] + 1'b1;
      end
    end
  end
  // hold counts cycles since the press (or last repeat); it is 0 in the press cycle
  always_comb begin
    rep = '0;
    for (int i = 0; i < 4; i++)
      rep[i] = stable[i] && hold[i] == (rpt[i] ? HW'(REPEAT_PERIOD) : HW'(REPEAT_DELAY));
  end
  assign press = stable & ~stable_q;
  assign ev    = press | (rep & 4'b1101);
  assign sel   = ev[2] ? 4'b0100 : ev[1] ? 4'b0010 : ev[3] ? 4'b1000 : ev[0] ? 4'b0001 : 4'b0000;
  assign c6_fall = c6_q & ~c6_s2;
  assign c6_rise = c6_s2 & ~c6_q;
  assign win     = !c6_s2 && (c6_fall || phase < PW'(LOAD_WINDOW));
  always_ff @(posedge clk_1000) begin
    if (restart || c6_fall) phase <= '0;
    else if (phase < PW'(LOAD_WINDOW)) phase <= phase + 1'b1;
  end
  always_ff @(posedge clk_1000) begin
    if (restart) begin
      state <= IDLE;
      q     <= '0;
    end else begin
      state <= state_n;
      q     <= q_n;
    end
  end
  always_comb begin
    state_n = state;
    q_n     = q;
    op      = 4'b0000;
    case (state)
      IDLE:  if (|ev) begin
        q_n     = sel;
        state_n = WAIT;
      end
      WAIT:  if (win) state_n = SHOW;
      SHOW:  begin
        op = q;
        if (c6_rise) state_n = CLEAR;
      end
      CLEAR: begin
        q_n     = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign pending = state != IDLE;
endmodule
